// File: rtl/chan_scan_mux.sv
// N-channel registered selector with manual select, auto-scan with programmable
// dwell, hold, channel-change strobe and out-of-range select flag.
module chan_scan_mux #(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned W     = 2,
  parameter  int unsigned DWELL = 50000000,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [N_CH*W-1:0] DATA_IN,
  input  logic [SEL_W-1:0]  SEL,
  input  logic              MODE,
  input  logic              HOLD,
  output logic [W-1:0]      DATA_OUT,
  output logic [SEL_W-1:0]  CH_OUT,
  output logic              STEP,
  output logic              SEL_ERR
);

  localparam int unsigned        CNT_W    = $clog2(DWELL + 1);
  localparam logic [SEL_W-1:0]   LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  ch_q;
  logic [CNT_W-1:0]  cnt;

  logic              sel_valid;
  logic              terminal;
  logic [SEL_W-1:0]  ch_next_scan;
  logic [W-1:0]      data_sel;

  // Non-power-of-two channel counts leave some SEL codes unused.
  assign sel_valid    = (32'(SEL) < N_CH);
  assign terminal     = (cnt == LAST_CNT);
  assign ch_next_scan = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
  assign data_sel     = DATA_IN[32'(ch_q) * W +: W];

  // Channel FSM, dwell counter and output stage share one register process.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      ch_q     <= '0;
      cnt      <= '0;
      DATA_OUT <= '0;
      CH_OUT   <= '0;
      STEP     <= 1'b0;
      SEL_ERR  <= 1'b0;
    end else begin
      DATA_OUT <= data_sel;
      CH_OUT   <= ch_q;
      STEP     <= (ch_q != CH_OUT);
      SEL_ERR  <= (state == MANUAL) && !sel_valid;

      unique case (state)
        IDLE: begin
          state <= MODE ? SCAN : MANUAL;
        end

        MANUAL: begin
          if (MODE) begin
            // Scan resumes from whatever channel is currently selected.
            state <= SCAN;
            if (!HOLD) cnt <= '0;
          end else if (!HOLD && sel_valid) begin
            ch_q <= SEL;
          end
        end

        SCAN: begin
          if (!MODE) begin
            // Mode change takes priority over a coincident terminal count.
            state <= MANUAL;
            if (!HOLD) begin
              cnt <= '0;
              if (sel_valid) ch_q <= SEL;
            end
          end else if (!HOLD) begin
            if (terminal) begin
              cnt  <= '0;
              ch_q <= ch_next_scan;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Self-checking bench for chan_scan_mux: directed scenarios plus randomized
// traffic against a behavioural model, on a 4-channel and a 3-channel instance.
module tb_chan_scan_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       hold;
  logic [1:0] sel;
  logic [7:0] din4;
  logic [5:0] din3;

  logic [1:0] dout4, ch4, dout3, ch3;
  logic       step4, err4, step3, err3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st;     // 0 idle, 1 manual, 2 scan
    int ch;
    int cnt;
    int dout;
    int chout;
    int step;
    int err;
  } mdl_t;

  mdl_t m4, m3;

  always #5 clk = ~clk;

  chan_scan_mux #(.N_CH(4), .W(2), .DWELL(3)) u4 (
    .CLOCK_50(clk), .RESET(rst), .DATA_IN(din4), .SEL(sel), .MODE(mode), .HOLD(hold),
    .DATA_OUT(dout4), .CH_OUT(ch4), .STEP(step4), .SEL_ERR(err4)
  );

  chan_scan_mux #(.N_CH(3), .W(2), .DWELL(1)) u3 (
    .CLOCK_50(clk), .RESET(rst), .DATA_IN(din3), .SEL(sel), .MODE(mode), .HOLD(hold),
    .DATA_OUT(dout3), .CH_OUT(ch3), .STEP(step3), .SEL_ERR(err3)
  );

  function automatic mdl_t mzero();
    mdl_t r;
    r = '{default: 0};
    return r;
  endfunction

  // One clock edge of the behavioural model.
  function automatic mdl_t mstep(mdl_t m, int n, int dw, int w, int din, int s, bit md, bit hd);
    mdl_t r;
    bit   valid;
    r       = m;
    valid   = (s < n);
    r.dout  = (din >> (m.ch * w)) & ((1 << w) - 1);
    r.chout = m.ch;
    r.step  = (m.ch != m.chout) ? 1 : 0;
    r.err   = (m.st == 1 && !valid) ? 1 : 0;
    if (m.st == 0) begin
      r.st = md ? 2 : 1;
    end else if (m.st == 1) begin
      if (md) begin
        r.st = 2;
        if (!hd) r.cnt = 0;
      end else if (!hd && valid) begin
        r.ch = s;
      end
    end else begin
      if (!md) begin
        r.st = 1;
        if (!hd) begin
          r.cnt = 0;
          if (valid) r.ch = s;
        end
      end else if (!hd) begin
        if (m.cnt == dw - 1) begin
          r.cnt = 0;
          r.ch  = (m.ch + 1) % n;
        end else begin
          r.cnt = m.cnt + 1;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("u4_dout", 32'(dout4), 32'(m4.dout));
    chk("u4_ch",   32'(ch4),   32'(m4.chout));
    chk("u4_step", 32'(step4), 32'(m4.step));
    chk("u4_err",  32'(err4),  32'(m4.err));
    chk("u3_dout", 32'(dout3), 32'(m3.dout));
    chk("u3_ch",   32'(ch3),   32'(m3.chout));
    chk("u3_step", 32'(step3), 32'(m3.step));
    chk("u3_err",  32'(err3),  32'(m3.err));
  endtask

  // Advance one clock; inputs are changed only after the #1 sample point.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      m4 = mzero();
      m3 = mzero();
    end else begin
      m4 = mstep(m4, 4, 3, 2, int'(din4), int'(sel), mode, hold);
      m3 = mstep(m3, 3, 1, 2, int'(din3), int'(sel), mode, hold);
    end
    #1 cmp_all();
  endtask

  // Assert reset between edges and check outputs clear before the next edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    m4 = mzero();
    m3 = mzero();
    cmp_all();
    chk("rst_dout4", 32'(dout4), 32'd0);
    chk("rst_ch4",   32'(ch4),   32'd0);
    chk("rst_step4", 32'(step4), 32'd0);
    chk("rst_err3",  32'(err3),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q[$];
    int at[$];
    int n;

    rst  = 1'b1;
    mode = 1'b0;
    hold = 1'b0;
    sel  = 2'd0;
    din4 = 8'b11_10_01_00;
    din3 = 6'b10_01_00;
    m4   = mzero();
    m3   = mzero();
    #2 cmp_all();
    cyc();
    cyc();

    // Manual select of channel 2: visible two edges after MANUAL is entered.
    sel = 2'd2;
    rst = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t1_dout", 32'(dout4), 32'd2);
    chk("t1_ch",   32'(ch4),   32'd2);
    chk("t1_step", 32'(step4), 32'd1);
    cyc();
    chk("t1_step_off", 32'(step4), 32'd0);

    // Out-of-range select on the 3-channel instance.
    sel = 2'd3;
    cyc();
    chk("t4_err", 32'(err3), 32'd1);
    chk("t4_ch",  32'(ch3),  32'd2);
    cyc();
    chk("t4_ch_keep", 32'(ch3), 32'd2);
    sel = 2'd1;
    cyc();
    chk("t4_err_clr", 32'(err3), 32'd0);

    // Auto-scan from reset: channels 1,2,3,0 with a STEP every 3 cycles.
    async_reset();
    mode = 1'b1;
    sel  = 2'd0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (step4) begin
        q.push_back(int'(ch4));
        at.push_back(i);
      end
    end
    chk("t2_pulses", 32'(q.size()), 32'd4);
    if (q.size() == 4) begin
      chk("t2_first_at", 32'(at[0]), 32'd4);
      for (int k = 0; k < 4; k++) begin
        chk("t2_seq", 32'(q[k]), 32'((k + 1) % 4));
        if (k > 0) chk("t2_gap", 32'(at[k] - at[k-1]), 32'd3);
      end
    end

    // Hold on channel 2 right after it is entered.
    for (int i = 0; i < 20 && !(m4.ch == 2 && m4.cnt == 0); i++) cyc();
    chk("t3_reach", 32'(m4.ch == 2 && m4.cnt == 0), 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din4 = 8'($urandom);
      cyc();
      chk("t3_hold_ch", 32'(ch4),   32'd2);
      chk("t3_data",    32'(dout4), 32'(din4[5:4]));
    end
    hold = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && ch4 != 2'd3; i++) begin
      cyc();
      n++;
    end
    chk("t3_resume", 32'(n), 32'd4);

    // Mode change on the terminal count: no advance, SEL wins.
    for (int i = 0; i < 20 && !(m4.st == 2 && m4.ch == 1 && m4.cnt == 2); i++) cyc();
    chk("t5_reach", 32'(m4.st == 2 && m4.ch == 1 && m4.cnt == 2), 32'd1);
    mode = 1'b0;
    sel  = 2'd0;
    cyc();
    chk("t5_ch_pre", 32'(ch4), 32'd1);
    cyc();
    chk("t5_ch", 32'(ch4), 32'd0);
    chk("t5_step", 32'(step4), 32'd1);

    // Asynchronous reset while scanning channel 3.
    mode = 1'b1;
    for (int i = 0; i < 30 && ch4 != 2'd3; i++) cyc();
    chk("t6_reach", 32'(ch4), 32'd3);
    async_reset();
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("t6_restart_ch",   32'(ch4),   32'd0);
    chk("t6_restart_step", 32'(step4), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      din4 = 8'($urandom);
      din3 = 6'($urandom);
      sel  = 2'($urandom);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      hold = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        cyc();
        rst = 1'b0;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
